// File: rtl/booth_product_accumulator.sv
// Saturating accumulator for signed Booth products, delivering sum, term count and sticky overflow.
// Result valid one cycle after the last beat; input stalls while a result waits for out_ready.
module booth_product_accumulator #(
    parameter int WIDTH     = 4,
    parameter int GUARD     = 4,
    parameter int CNT_WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [2*WIDTH-1:0]      in_product,
    input  logic                           in_last,
    input  logic                           clear,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [2*WIDTH+GUARD-1:0] out_sum,
    output logic [CNT_WIDTH-1:0]           out_count,
    output logic                           out_overflow
);

    localparam int ACC_W = 2*WIDTH + GUARD;

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] out_sum_q;
    logic [CNT_WIDTH-1:0]    out_count_q;
    logic                    out_ovf_q;
    logic [ACC_W:0]          sum_wide;

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign out_sum      = out_sum_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

    // One extra bit of headroom: disagreement of the top two bits means the sum left the ACC_W range.
    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W+1-2*WIDTH){in_product[2*WIDTH-1]}}, in_product};
        acc_d    = sum_wide[ACC_W-1:0];
        ovf_d    = ovf_q;
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            ovf_d = 1'b1;
            acc_d = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (state_q == ACCUM) begin
            if (clear) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (in_valid) begin
                if (in_last) begin
                    out_sum_q   <= acc_d;
                    out_count_q <= cnt_d;
                    out_ovf_q   <= ovf_d;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                    state_q     <= HOLD;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_d;
                end
            end
        end else if (out_ready) begin
            state_q <= ACCUM;
        end
    end

endmodule
